// File: rtl/victim_sel.sv
// Replacement-victim selector: decodes the per-set PLRU tree into a victim way and runs a writeback handshake for dirty victims.
// Optional feature macro: VICTIM_INVALID_FIRST_EN (when defined, an invalid way is chosen ahead of the PLRU decode).
module victim_sel #(
  parameter int IDX_W = 13,
  parameter int WAYS  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             miss_req,
  input  logic [IDX_W-1:0] miss_idx,
  output logic             miss_rdy,
  output logic [IDX_W-1:0] lru_ra,
  input  logic [2:0]       lru_rd,
  input  logic [WAYS-1:0]  vld_rd,
  input  logic [WAYS-1:0]  dty_rd,
  output logic             wb_req,
  output logic [IDX_W-1:0] wb_idx,
  output logic [WAYS-1:0]  wb_way,
  input  logic             wb_ack,
  output logic             victim_vld,
  output logic [WAYS-1:0]  victim_way,
  output logic [15:0]      wb_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_DECIDE = 3'd2,
    S_WB     = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       lru_q, lru_d;
  logic [WAYS-1:0]  vld_q, vld_d;
  logic [WAYS-1:0]  dty_q, dty_d;
  logic [WAYS-1:0]  victim_q, victim_d;
  logic [IDX_W-1:0] wb_idx_q, wb_idx_d;
  logic [WAYS-1:0]  wb_way_q, wb_way_d;
  logic [15:0]      wb_cnt_q, wb_cnt_d;

  logic [WAYS-1:0]  plru_way;
  logic [WAYS-1:0]  sel_way;
  logic             sel_dirty;

  // b2 points away from the most recently used half; b1/b0 pick within that half.
  always_comb begin
    plru_way = '0;
    if (!lru_q[2]) plru_way = lru_q[1] ? 4'b0100 : 4'b1000;
    else           plru_way = lru_q[0] ? 4'b0001 : 4'b0010;
  end

`ifdef VICTIM_INVALID_FIRST_EN
  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    sel_way = plru_way;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        sel_way    = '0;
        sel_way[i] = 1'b1;
      end
    end
  end
`else
  assign sel_way = plru_way;
`endif

  assign sel_dirty = |(sel_way & vld_q & dty_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      lru_q    <= '0;
      vld_q    <= '0;
      dty_q    <= '0;
      victim_q <= '0;
      wb_idx_q <= '0;
      wb_way_q <= '0;
      wb_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lru_q    <= lru_d;
      vld_q    <= vld_d;
      dty_q    <= dty_d;
      victim_q <= victim_d;
      wb_idx_q <= wb_idx_d;
      wb_way_q <= wb_way_d;
      wb_cnt_q <= wb_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lru_d    = lru_q;
    vld_d    = vld_q;
    dty_d    = dty_q;
    victim_d = victim_q;
    wb_idx_d = wb_idx_q;
    wb_way_d = wb_way_q;
    wb_cnt_d = wb_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          idx_d   = miss_idx;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        lru_d   = lru_rd;
        vld_d   = vld_rd;
        dty_d   = dty_rd;
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        victim_d = sel_way;
        if (sel_dirty) begin
          wb_idx_d = idx_q;
          wb_way_d = sel_way;
          if (wb_cnt_q != 16'hFFFF) wb_cnt_d = wb_cnt_q + 16'd1;
          state_d  = S_WB;
        end else begin
          state_d  = S_DONE;
        end
      end
      S_WB: begin
        if (wb_ack) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign miss_rdy   = (state_q == S_IDLE);
  assign lru_ra     = idx_q;
  assign wb_req     = (state_q == S_WB);
  assign wb_idx     = wb_idx_q;
  assign wb_way     = wb_way_q;
  assign victim_vld = (state_q == S_DONE);
  assign victim_way = victim_q;
  assign wb_cnt     = wb_cnt_q;

endmodule

// File: tb/tb_victim_sel.sv
// Scoreboard bench for victim_sel: expected victims queued at request time, checked when victim_vld pulses.
module tb_victim_sel;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_req;
  logic [12:0] miss_idx;
  logic        miss_rdy;
  logic [12:0] lru_ra;
  logic [2:0]  lru_rd;
  logic [3:0]  vld_rd;
  logic [3:0]  dty_rd;
  logic        wb_req;
  logic [12:0] wb_idx;
  logic [3:0]  wb_way;
  logic        wb_ack;
  logic        victim_vld;
  logic [3:0]  victim_way;
  logic [15:0] wb_cnt;

  victim_sel dut (
    .clk        (clk),
    .reset      (reset),
    .miss_req   (miss_req),
    .miss_idx   (miss_idx),
    .miss_rdy   (miss_rdy),
    .lru_ra     (lru_ra),
    .lru_rd     (lru_rd),
    .vld_rd     (vld_rd),
    .dty_rd     (dty_rd),
    .wb_req     (wb_req),
    .wb_idx     (wb_idx),
    .wb_way     (wb_way),
    .wb_ack     (wb_ack),
    .victim_vld (victim_vld),
    .victim_way (victim_way),
    .wb_cnt     (wb_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  way;
    logic        dirty;
    logic [12:0] idx;
    int          wbcyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          ack_cyc = 0;
  int          wb_hi = 0;
  logic        vld_prev = 1'b0;
  logic [15:0] cnt_m = 16'h0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_way(input logic [2:0] lru, input logic [3:0] vld);
    logic [3:0] w;
    if (lru[2]) w = lru[0] ? 4'b0001 : 4'b0010;
    else        w = lru[1] ? 4'b0100 : 4'b1000;
`ifdef VICTIM_INVALID_FIRST_EN
    if      (!vld[0]) w = 4'b0001;
    else if (!vld[1]) w = 4'b0010;
    else if (!vld[2]) w = 4'b0100;
    else if (!vld[3]) w = 4'b1000;
`endif
    return w;
  endfunction

  // Monitor: samples on the falling edge, pops the scoreboard on each victim_vld pulse.
  always @(negedge clk) begin
    if (reset) begin
      vld_prev = 1'b0;
    end else begin
      if (vld_prev) chk("vld_pulse_width", victim_vld, 1'b0);
      vld_prev = victim_vld;
      if (miss_req && miss_rdy) begin
        acc_cyc = cyc;
        wb_hi   = 0;
      end
      if (wb_req) wb_hi++;
      if (wb_req && wb_ack) ack_cyc = cyc;
      if (victim_vld) begin
        if (sb.size() == 0) begin
          chk("unexpected_victim_vld", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("victim_way", victim_way, e.way);
          chk("wb_req_low_in_done", wb_req, 1'b0);
          chk("wb_cnt", wb_cnt, cnt_m);
          if (e.dirty) begin
            chk("dirty_latency", cyc, ack_cyc + 1);
            chk("wb_req_cycles", wb_hi, e.wbcyc);
            chk("wb_idx", wb_idx, e.idx);
            chk("wb_way", wb_way, e.way);
          end else begin
            chk("clean_latency", cyc, acc_cyc + 3);
            chk("no_wb_req", wb_hi, 0);
          end
        end
      end
    end
  end

  task automatic issue(input logic [12:0] idx, input logic [2:0] lru, input logic [3:0] vld,
                       input logic [3:0] dty, output exp_t e);
    e.way   = model_way(lru, vld);
    e.dirty = |(e.way & vld & dty);
    e.idx   = idx;
    e.wbcyc = 0;
    @(posedge clk); #1;
    chk("miss_rdy_idle", miss_rdy, 1'b1);
    miss_idx = idx;
    lru_rd   = lru;
    vld_rd   = vld;
    dty_rd   = dty;
    miss_req = 1'b1;
    @(posedge clk); #1;
    miss_req = 1'b0;
    chk("lru_ra", lru_ra, idx);
    chk("miss_rdy_busy", miss_rdy, 1'b0);
  endtask

  task automatic wait_wb_req();
    bit seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (wb_req) begin
        seen = 1;
        break;
      end
    end
    chk("wb_req_seen", seen, 1'b1);
  endtask

  task automatic run_miss(input logic [12:0] idx, input logic [2:0] lru, input logic [3:0] vld,
                          input logic [3:0] dty, input int d);
    exp_t e;
    issue(idx, lru, vld, dty, e);
    e.wbcyc = d + 1;
    if (e.dirty && cnt_m != 16'hFFFF) cnt_m++;
    sb.push_back(e);
    if (e.dirty) begin
      wait_wb_req();
      for (int j = 0; j <= d; j++) begin
        if (j == d) wb_ack = 1'b1;
        @(posedge clk); #1;
      end
      wb_ack = 1'b0;
    end
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    exp_t e;
    reset    = 1'b1;
    miss_req = 1'b0;
    miss_idx = '0;
    lru_rd   = '0;
    vld_rd   = '0;
    dty_rd   = '0;
    wb_ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_miss_rdy", miss_rdy, 1'b1);
    chk("rst_wb_req", wb_req, 1'b0);
    chk("rst_victim_vld", victim_vld, 1'b0);
    chk("rst_victim_way", victim_way, 4'h0);
    chk("rst_wb_way", wb_way, 4'h0);
    chk("rst_wb_idx", wb_idx, 13'h0);
    chk("rst_lru_ra", lru_ra, 13'h0);
    chk("rst_wb_cnt", wb_cnt, 16'h0);

    // Clean victims across the four decode paths
    run_miss(13'h0ABC, 3'b000, 4'hF, 4'h0, 0);
    run_miss(13'h0ABC, 3'b010, 4'hF, 4'h0, 0);
    run_miss(13'h0ABC, 3'b100, 4'hF, 4'h0, 0);
    run_miss(13'h0ABC, 3'b101, 4'hF, 4'h0, 0);
    // Dirty victim with delayed ack, then same-cycle ack
    run_miss(13'h1FFF, 3'b100, 4'hF, 4'b0010, 4);
    chk("wb_cnt_after_first_wb", wb_cnt, 16'd1);
    run_miss(13'h0123, 3'b000, 4'hF, 4'b1000, 0);
    // Invalid way present
    run_miss(13'h0055, 3'b000, 4'b1011, 4'h0, 0);
    run_miss(13'h0056, 3'b000, 4'b1011, 4'b1000, 2);

    // Reset while in WB
    issue(13'h0777, 3'b101, 4'hF, 4'b0001, e);
    wait_wb_req();
    wb_ack = 1'b1;
    reset  = 1'b1;
    @(posedge clk); #1;
    reset  = 1'b0;
    wb_ack = 1'b0;
    cnt_m  = 16'h0;
    chk("rst_mid_wb_req", wb_req, 1'b0);
    chk("rst_mid_miss_rdy", miss_rdy, 1'b1);
    chk("rst_mid_wb_cnt", wb_cnt, 16'h0);
    run_miss(13'h0777, 3'b101, 4'hF, 4'b0001, 1);

    // Saturation of the writeback counter
    @(posedge clk); #1;
    dut.wb_cnt_q = 16'hFFFE;
    cnt_m = 16'hFFFE;
    run_miss(13'h0100, 3'b010, 4'hF, 4'b0100, 0);
    chk("wb_cnt_at_max", wb_cnt, 16'hFFFF);
    run_miss(13'h0101, 3'b010, 4'hF, 4'b0100, 0);
    chk("wb_cnt_saturated", wb_cnt, 16'hFFFF);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/victim_sel.md
# victim_sel

Replacement-victim selector for the 4-way, 8192-set L1. It reads the per-set 3-bit pseudo-LRU tree that the LRU update regfile writes on every hit, decodes it to a victim way, and checks the victim's valid/dirty state. When the victim is dirty, it runs a writeback request/acknowledge handshake, then reports the chosen way to the miss/fill controller. It is the decode/consumer side of the PLRU encoding: the regfile encodes accesses, this block decodes them into a replacement choice.

## Interface
Parameters:
- IDX_W, 13, set index width (8192 sets)
- WAYS, 4, associativity; fixed at 4 because the PLRU tree is 3 bits

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- miss_req  in  1  miss needs a victim; held with miss_idx until accepted
- miss_idx  in  13  set index of the miss
- miss_rdy  out  1  high only in IDLE; a request is accepted when miss_req & miss_rdy
- lru_ra  out  13  read address to the LRU regfile (asynchronous read)
- lru_rd  in  3  PLRU bits {b2,b1,b0} for lru_ra
- vld_rd  in  4  per-way valid bits for lru_ra, same address
- dty_rd  in  4  per-way dirty bits for lru_ra, same address
- wb_req  out  1  writeback request; held until wb_ack
- wb_idx  out  13  set index of the writeback
- wb_way  out  4  one-hot way to write back
- wb_ack  in  1  writeback accepted
- victim_vld  out  1  one-cycle pulse: victim_way is final
- victim_way  out  4  one-hot victim; held until the next accepted request
- wb_cnt  out  16  count of issued writebacks; saturates at 16'hFFFF

## Operation
- FSM states: IDLE, LOOKUP, DECIDE, WB, DONE.
- IDLE: miss_rdy=1. On miss_req, capture miss_idx into idx_q and go to LOOKUP.
- LOOKUP: lru_ra=idx_q. Register lru_rd, vld_rd and dty_rd. Go to DECIDE.
  - lru_ra equals idx_q in every state (0 after reset).
- PLRU decode, inverse of the regfile update rules:
  - b2=0: the recent access was in ways 0/1, so the victim is in 2/3. b1=0 selects way3; b1=1 selects way2.
  - b2=1: the victim is in 0/1. b0=0 selects way1; b0=1 selects way0.
- DECIDE: register victim_way.
  - If the victim is valid and dirty: go to WB. Load wb_idx=idx_q and wb_way=victim. Increment wb_cnt unless it is saturated.
  - Otherwise: go to DONE.
- WB: wb_req=1, with wb_idx and wb_way stable. When wb_ack=1, go to DONE; wb_req drops the following cycle.
- DONE: victim_vld=1 for exactly one cycle. Return to IDLE.
- wb_ack outside WB is ignored.
- The block does not write the LRU bits. The fill path's subsequent access updates them.
- Reset values: state=IDLE, miss_rdy=1, wb_req=0, victim_vld=0, victim_way=0, wb_way=0, wb_idx=0, lru_ra=0, wb_cnt=0.
- Reset mid-operation: the FSM returns to IDLE the next cycle and wb_req drops.
  - An in-flight request is lost; the requester re-issues it.
  - wb_cnt clears.

## Timing
- Request accepted at cycle T (miss_req & miss_rdy).
- LOOKUP at T+1; arrays are sampled at the end of T+1.
- DECIDE at T+2.
- Clean or invalid victim: victim_vld at T+3. Back in IDLE at T+4, so the next accept is possible at T+4.
- Dirty victim: wb_req rises at T+3. If wb_ack arrives in cycle N ≥ T+3, victim_vld is at N+1.
  - Minimum dirty latency: victim_vld at T+4.
- wb_ack in the same cycle wb_req rises is legal and completes that cycle.
- miss_req while not in IDLE is ignored; it is not queued.

## Configuration
- VICTIM_INVALID_FIRST_EN:
  - Defined: if any vld_rd bit registered in LOOKUP is 0, the victim is the lowest-numbered invalid way and the PLRU decode is bypassed. An invalid way is never dirty, so no writeback is issued.
  - Undefined: the victim is always the PLRU decode, regardless of valid bits.

## Test plan
- Reset then idle: all outputs at their reset values; miss_rdy=1; wb_cnt=0.
- lru_rd=3'b000, vld=4'hF, dty=4'h0, idx=13'h0ABC: victim_way=4'b1000 and victim_vld exactly 3 cycles after accept, with no wb_req. Then repeat with lru_rd=3'b010 → 4'b0100, 3'b100 → 4'b0010, and 3'b101 → 4'b0001.
- lru_rd=3'b100, vld=4'hF, dty=4'b0010, idx=13'h1FFF, wb_ack delayed 5 cycles: wb_req held 5 cycles with wb_idx=13'h1FFF and wb_way=4'b0010; victim_vld one cycle after wb_ack; wb_cnt=1.
- vld=4'b1011, lru_rd=3'b000: with VICTIM_INVALID_FIRST_EN defined, victim=4'b0100; without it, victim=4'b1000.
- Assert reset during WB: wb_req=0 and state=IDLE the next cycle; wb_cnt=0; a new request then completes normally.
- Preload wb_cnt near saturation and issue 2 more dirty writebacks: wb_cnt stops at 16'hFFFF and does not wrap.
